sim_top: RTL and testbench

- Top-level simulation harness for the difftest environment. It runs a free-running cycle counter and emits a fixed boot banner over a simple character UART.
- It polls a UART input channel and echoes any received characters.
- It keeps a perf counter of emitted characters, which the bench can clear or dump as hex text on the UART.
- Inside the log window it emits heartbeat characters.

---
 rtl/sim_top_if.sv | 21 ++
 rtl/sim_top.sv | 138 +++++++++++++
 tb/tb_sim_top.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sim_top_if.sv
// Character UART between the sim harness and the bench: output pulses plus an input poll.
interface sim_top_if;
  logic       out_valid;
  logic [7:0] out_ch;
  logic       in_valid;
  logic [7:0] in_ch;

  modport master (
    output out_valid,
    output out_ch,
    output in_valid,
    input  in_ch
  );

  modport slave (
    input  out_valid,
    input  out_ch,
    input  in_valid,
    output in_ch
  );
endinterface

// File: rtl/sim_top.sv
// Difftest sim harness: cycle counter, boot banner, UART echo, perf counter dump and heartbeat.
module sim_top #(
  parameter int unsigned              BANNER_LEN    = 7,
  parameter logic [8*BANNER_LEN-1:0]  BANNER        = "SimTop\n",
  parameter int unsigned              CHAR_GAP      = 4,
  parameter int unsigned              POLL_INTERVAL = 16,
  parameter int unsigned              HEARTBEAT     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] io_logCtrl_log_begin,
  input  logic [63:0] io_logCtrl_log_end,
  input  logic [63:0] io_logCtrl_log_level,
  input  logic        io_perfInfo_clean,
  input  logic        io_perfInfo_dump,
  sim_top_if.master   uart
);

  typedef enum logic [2:0] {SrcNone, SrcDump, SrcEcho, SrcBanner, SrcHeart} src_e;

  localparam logic [7:0]  BannerEnd = 8'(BANNER_LEN);
  localparam logic [15:0] GapLoad   = 16'(CHAR_GAP - 1);
  localparam logic [3:0]  DumpLast  = 4'd9;

  logic [63:0] cycle_q;
  logic [31:0] perf_q;
  logic        out_valid_q, in_valid_q;
  logic [7:0]  out_ch_q;
  logic [15:0] gap_q;
  logic [7:0]  banner_idx_q;
  logic        echo_full_q;
  logic [7:0]  echo_ch_q;
  logic        dump_active_q;
  logic [3:0]  dump_idx_q;
  logic [31:0] dump_sh_q;
  logic        hb_pend_q;

  src_e        src;
  logic [7:0]  launch_ch, banner_ch, dump_ch;
  logic        window, hb_req, poll_next;

  assign uart.out_valid = out_valid_q;
  assign uart.out_ch    = out_ch_q;
  assign uart.in_valid  = in_valid_q;

  always_comb begin
    window    = (cycle_q >= io_logCtrl_log_begin) &&
                ((io_logCtrl_log_end == 64'd0) || (cycle_q < io_logCtrl_log_end));
    hb_req    = (io_logCtrl_log_level != 64'd0) && window &&
                ((cycle_q % 64'(HEARTBEAT)) == 64'd0);
    poll_next = ((cycle_q + 64'd1) % 64'(POLL_INTERVAL)) == 64'(POLL_INTERVAL - 1);
  end

  always_comb begin
    banner_ch = BANNER[8*(BANNER_LEN - 1 - 32'(banner_idx_q)) +: 8];
    dump_ch   = 8'h0a;
    if (dump_idx_q == 4'd0) begin
      dump_ch = "P";
    end else if (dump_idx_q != DumpLast) begin
      dump_ch = (dump_sh_q[31:28] < 4'd10) ? (8'h30 + {4'd0, dump_sh_q[31:28]})
                                           : (8'h37 + {4'd0, dump_sh_q[31:28]});
    end
  end

  // Priority: dump, echo, banner, heartbeat; only on edges outside the inter-character gap.
  always_comb begin
    src       = SrcNone;
    launch_ch = 8'h00;
    if (gap_q == 16'd0) begin
      if (dump_active_q)                    src = SrcDump;
      else if (echo_full_q)                 src = SrcEcho;
      else if (banner_idx_q != BannerEnd)   src = SrcBanner;
      else if (hb_pend_q)                   src = SrcHeart;
    end
    unique case (src)
      SrcDump:   launch_ch = dump_ch;
      SrcEcho:   launch_ch = echo_ch_q;
      SrcBanner: launch_ch = banner_ch;
      SrcHeart:  launch_ch = ".";
      default:   launch_ch = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_q       <= 64'd0;
      perf_q        <= 32'd0;
      out_valid_q   <= 1'b0;
      out_ch_q      <= 8'h00;
      in_valid_q    <= 1'b0;
      gap_q         <= 16'd0;
      banner_idx_q  <= 8'd0;
      echo_full_q   <= 1'b0;
      echo_ch_q     <= 8'h00;
      dump_active_q <= 1'b0;
      dump_idx_q    <= 4'd0;
      dump_sh_q     <= 32'd0;
      hb_pend_q     <= 1'b0;
    end else begin
      cycle_q     <= cycle_q + 64'd1;
      out_valid_q <= (src != SrcNone);
      in_valid_q  <= poll_next;

      if (src != SrcNone) begin
        out_ch_q <= launch_ch;
        gap_q    <= GapLoad;
      end else if (gap_q != 16'd0) begin
        gap_q <= gap_q - 16'd1;
      end

      if (io_perfInfo_clean)    perf_q <= 32'd0;
      else if (src != SrcNone)  perf_q <= perf_q + 32'd1;

      if (src == SrcBanner) banner_idx_q <= banner_idx_q + 8'd1;

      // A full buffer drops the new sample, even if it is draining on this edge.
      if (in_valid_q && !echo_full_q && (uart.in_ch != 8'hff)) begin
        echo_full_q <= 1'b1;
        echo_ch_q   <= uart.in_ch;
      end else if (src == SrcEcho) begin
        echo_full_q <= 1'b0;
      end

      if (!dump_active_q && io_perfInfo_dump) begin
        dump_active_q <= 1'b1;
        dump_idx_q    <= 4'd0;
        dump_sh_q     <= perf_q;
      end else if (src == SrcDump) begin
        dump_idx_q <= dump_idx_q + 4'd1;
        if (dump_idx_q == DumpLast) dump_active_q <= 1'b0;
        if (dump_idx_q != 4'd0)     dump_sh_q     <= {dump_sh_q[27:0], 4'd0};
      end

      hb_pend_q <= (hb_pend_q && (src != SrcHeart) && window) || hb_req;
    end
  end

endmodule

// File: tb/tb_sim_top.sv
// Scoreboard bench for sim_top: directed stimulus pushes expected characters, a monitor pops them.
module tb_sim_top;

  typedef struct {
    logic [7:0] ch;
    longint     cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] log_begin = 64'd0;
  logic [63:0] log_end   = 64'd0;
  logic [63:0] log_level = 64'd0;
  logic        clean = 1'b0;
  logic        dump  = 1'b0;

  exp_t        sb[$];
  longint      tb_cyc   = 0;
  logic        rst_seen = 1'b1;
  int          tests    = 0;
  int          fails    = 0;
  logic [55:0] banner   = "SimTop\n";

  sim_top_if uart ();

  sim_top dut (
    .clock                (clock),
    .reset                (reset),
    .io_logCtrl_log_begin (log_begin),
    .io_logCtrl_log_end   (log_end),
    .io_logCtrl_log_level (log_level),
    .io_perfInfo_clean    (clean),
    .io_perfInfo_dump     (dump),
    .uart                 (uart)
  );

  always #5 clock = ~clock;

  // Bench-side cycle count, mirroring the harness cycle definition.
  always @(posedge clock) begin
    rst_seen <= !reset;
    if (!reset) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  always @(negedge clock) begin
    if (rst_seen) begin
      tests++;
      if (uart.out_valid !== 1'b0 || uart.out_ch !== 8'h00 || uart.in_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: out_valid=%0b out_ch=%02h in_valid=%0b, required 0 00 0",
                 uart.out_valid, uart.out_ch, uart.in_valid);
      end
    end else begin
      tests++;
      if (uart.in_valid !== ((tb_cyc % 16) == 15)) begin
        fails++;
        $display("FAIL poll_pulse: cycle %0d in_valid=%0b, required %0b",
                 tb_cyc, uart.in_valid, ((tb_cyc % 16) == 15));
      end
      if (uart.out_valid !== 1'b0) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_char: cycle %0d ch=%02h, required no output",
                   tb_cyc, uart.out_ch);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (uart.out_valid !== 1'b1 || uart.out_ch !== e.ch || tb_cyc != e.cyc) begin
            fails++;
            $display("FAIL uart_char: got ch=%02h at cycle %0d, required ch=%02h at cycle %0d",
                     uart.out_ch, tb_cyc, e.ch, e.cyc);
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] c, input longint cyc);
    exp_t e;
    e.ch  = c;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  task automatic push_dump(input logic [31:0] v, input longint start);
    push("P", start);
    for (int i = 0; i < 8; i++) push(hexc(v[31-4*i -: 4]), start + 4 * (i + 1));
    push(8'h0a, start + 36);
  endtask

  task automatic push_banner(input int count);
    for (int k = 0; k < count; k++) push(banner[55-8*k -: 8], 1 + 4 * k);
  endtask

  task automatic wait_cyc(input longint n);
    int guard;
    guard = 0;
    while (tb_cyc < n && guard < 20000) begin
      @(posedge clock);
      #1;
      guard++;
    end
  endtask

  task automatic pulse_dump(input longint n, input logic with_clean);
    wait_cyc(n);
    dump  = 1'b1;
    clean = with_clean;
    wait_cyc(n + 1);
    dump  = 1'b0;
    clean = 1'b0;
  endtask

  task automatic poll_char(input longint n, input logic [7:0] c);
    wait_cyc(n);
    uart.in_ch = c;
    wait_cyc(n + 1);
    uart.in_ch = 8'hff;
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
  endtask

  initial begin
    uart.in_ch = 8'hff;
    reset_cycles(3);
    push_banner(7);

    pulse_dump(100, 1'b0);
    push_dump(32'h0000_0007, 102);
    pulse_dump(110, 1'b0);                 // mid-stream, must be ignored
    pulse_dump(200, 1'b1);                 // clean+dump snapshots the pre-clear value
    push_dump(32'h0000_0011, 202);
    pulse_dump(300, 1'b0);
    push_dump(32'h0000_000a, 302);

    poll_char(399, 8'h41);
    push("A", 401);
    pulse_dump(420, 1'b0);
    push_dump(32'h0000_0015, 422);
    poll_char(431, 8'h42);                 // waits behind the dump stream
    push("B", 462);
    poll_char(447, 8'h43);                 // buffer full, dropped
    pulse_dump(500, 1'b0);
    push_dump(32'h0000_0020, 502);

    wait_cyc(600);
    log_level = 64'd1;
    log_begin = 64'd2048;
    log_end   = 64'd4096;
    push(".", 2050);
    push(".", 3074);
    wait_cyc(4200);
    log_end = 64'd0;
    push(".", 5122);
    push(".", 6146);
    wait_cyc(6300);
    log_level = 64'd0;

    wait_cyc(6400);
    reset_cycles(2);
    push_banner(3);
    wait_cyc(10);
    reset_cycles(2);                       // aborts the banner after "Sim"
    push_banner(7);
    pulse_dump(100, 1'b0);
    push_dump(32'h0000_0007, 102);
    wait_cyc(200);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_chars: %0d expected characters never appeared, required 0",
               sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
